// File: rtl/or1200_dec_fsm.sv
`timescale 1ns/1ps
// or1200_dec_fsm: load-path decryption engine between dcache and LSU.
// Captures a load word on ack, runs ROUNDS keyed rounds, then pulses unstall.
// Ports:
//   clk, rst (async, active-low)
//   ack_i, lsu_we          : cache ack and LSU store flag
//   dat_i, adr_i, key_i    : ciphertext, address, key (sampled at capture)
//   enc_fsm_unstall        : one-cycle pulse, plaintext ready
//   dat_o                  : registered plaintext
//   busy_o                 : high in RUN or DONE
module or1200_dec_fsm #(
  parameter int unsigned ROUNDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ack_i,
  input  logic        lsu_we,
  input  logic [31:0] dat_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] key_i,
  output logic        enc_fsm_unstall,
  output logic [31:0] dat_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t      state;
  state_t      nxt;
  logic [3:0]  rnd;
  logic [31:0] d;
  logic [31:0] a;
  logic [31:0] k;
  logic [31:0] round;
  logic        cap;
  logic        last;

  assign cap   = (state == IDLE) && ack_i && !lsu_we;
  assign last  = (state == RUN) && (rnd == LAST);
  assign round = {d[26:0], d[31:27]}
               ^ (k + a + {28'd0, rnd});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Encoding 2'd3 is unreachable; the default sends it home.
  always_comb begin
    nxt = IDLE;
    case (state)
      IDLE:    nxt = cap  ? RUN  : IDLE;
      RUN:     nxt = last ? DONE : RUN;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_o          = 1'b0;
    enc_fsm_unstall = 1'b0;
    case (state)
      RUN:  busy_o = 1'b1;
      DONE: begin
        busy_o          = 1'b1;
        enc_fsm_unstall = 1'b1;
      end
      default: begin
        busy_o          = 1'b0;
        enc_fsm_unstall = 1'b0;
      end
    endcase
  end

  // Only the final round result is exposed on dat_o.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rnd   <= 4'd0;
      d     <= 32'd0;
      a     <= 32'd0;
      k     <= 32'd0;
      dat_o <= 32'd0;
    end else if (cap) begin
      rnd <= 4'd0;
      d   <= dat_i;
      a   <= adr_i;
      k   <= key_i;
    end else if (state == RUN) begin
      d <= round;
      if (last) begin
        dat_o <= round;
      end else begin
        rnd <= rnd + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_or1200_dec_fsm.sv
`timescale 1ns/1ps
// tb_or1200_dec_fsm: three instances (ROUNDS 1,2,4) on shared stimulus,
// checked against a transaction-level model plus literal expectations.
module tb_or1200_dec_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ack_i = 1'b0;
  logic        lsu_we = 1'b0;
  logic [31:0] dat_i = 32'd0;
  logic [31:0] adr_i = 32'd0;
  logic [31:0] key_i = 32'd0;

  logic        unst [3];
  logic [31:0] dato [3];
  logic        bsy  [3];

  localparam int RR [3] = '{1, 2, 4};

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  or1200_dec_fsm #(.ROUNDS(1)) u1 (
    .clk(clk), .rst(rst), .ack_i(ack_i), .lsu_we(lsu_we),
    .dat_i(dat_i), .adr_i(adr_i), .key_i(key_i),
    .enc_fsm_unstall(unst[0]), .dat_o(dato[0]), .busy_o(bsy[0])
  );
  or1200_dec_fsm #(.ROUNDS(2)) u2 (
    .clk(clk), .rst(rst), .ack_i(ack_i), .lsu_we(lsu_we),
    .dat_i(dat_i), .adr_i(adr_i), .key_i(key_i),
    .enc_fsm_unstall(unst[1]), .dat_o(dato[1]), .busy_o(bsy[1])
  );
  or1200_dec_fsm #(.ROUNDS(4)) u4 (
    .clk(clk), .rst(rst), .ack_i(ack_i), .lsu_we(lsu_we),
    .dat_i(dat_i), .adr_i(adr_i), .key_i(key_i),
    .enc_fsm_unstall(unst[2]), .dat_o(dato[2]), .busy_o(bsy[2])
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dec(input logic [31:0] c,
    input logic [31:0] kk, input logic [31:0] aa, input int r);
    logic [31:0] x;
    x = c;
    for (int i = 0; i < r; i++)
      x = {x[26:0], x[31:27]} ^ (kk + aa + 32'(i));
    return x;
  endfunction

  // Model: t = cycles since capture (0 = idle); whole result computed at once.
  int          t    [3];
  logic [31:0] res  [3];
  logic [31:0] mdat [3];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        t[i]    <= 0;
        res[i]  <= 32'd0;
        mdat[i] <= 32'd0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (t[i] == 0) begin
          if (ack_i && !lsu_we) begin
            t[i]   <= 1;
            res[i] <= dec(dat_i, key_i, adr_i, RR[i]);
          end
        end else begin
          if (t[i] == RR[i]) mdat[i] <= res[i];
          t[i] <= (t[i] == RR[i] + 1) ? 0 : t[i] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(t[i] != 0));
        chk($sformatf("unst%0d", i), 32'(unst[i]),
            32'(t[i] == RR[i] + 1));
        chk($sformatf("dat%0d", i), dato[i], mdat[i]);
      end
    end
  end

  task automatic load(input logic [31:0] d, input logic [31:0] k,
                      input logic [31:0] a);
    ack_i  = 1'b1;
    lsu_we = 1'b0;
    dat_i  = d;
    key_i  = k;
    adr_i  = a;
    @(negedge clk);
    ack_i = 1'b0;
  endtask

  int pc;
  int pcyc;
  logic [31:0] held;
  logic [31:0] ref4;

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_dat", dato[i], 32'd0);
      chk("rst_busy", 32'(bsy[i]), 32'd0);
      chk("rst_unst", 32'(unst[i]), 32'd0);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // single / two rounds on 1, key=adr=0
    load(32'h1, 32'h0, 32'h0);
    @(negedge clk);
    chk("r1_unst_c2", 32'(unst[0]), 32'd1);
    chk("r1_dat_c2", dato[0], 32'h20);
    chk("r2_dat_c2", dato[1], 32'h0);
    @(negedge clk);
    chk("r1_unst_c3", 32'(unst[0]), 32'd0);
    chk("r2_unst_c3", 32'(unst[1]), 32'd1);
    chk("r2_dat_c3", dato[1], 32'h401);
    repeat (4) @(negedge clk);

    // key + adr wraps to zero
    load(32'h0, 32'hFFFFFFFF, 32'h1);
    @(negedge clk);
    chk("wrap_unst", 32'(unst[0]), 32'd1);
    chk("wrap_dat1", dato[0], 32'h0);
    @(negedge clk);
    chk("wrap_dat2", dato[1], 32'h1);
    repeat (2) @(negedge clk);
    chk("wrap_dat4", dato[2], 32'h443);
    repeat (2) @(negedge clk);

    // stores ignored
    held = dato[0];
    ack_i  = 1'b1;
    lsu_we = 1'b1;
    for (int c = 0; c < 20; c++) begin
      dat_i = $urandom;
      key_i = $urandom;
      adr_i = $urandom;
      @(negedge clk);
      chk("st_busy", 32'(bsy[2]), 32'd0);
      chk("st_unst", 32'(unst[2]), 32'd0);
    end
    ack_i  = 1'b0;
    lsu_we = 1'b0;
    chk("st_dat", dato[0], held);
    @(negedge clk);

    // key change and stray ack in cycle 2
    ref4 = dec(32'h12345678, 32'h0000A5A5, 32'h100, 4);
    load(32'h12345678, 32'h0000A5A5, 32'h100);
    pc = 0;
    pcyc = -1;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) @(negedge clk);
      if (c == 2) begin
        ack_i = 1'b1;
        key_i = 32'hDEADBEEF;
        dat_i = 32'hCAFEF00D;
      end
      if (c == 3) ack_i = 1'b0;
      if (unst[2]) begin
        pc++;
        pcyc = c;
      end
      if (c == 5) chk("mid_dat", dato[2], ref4);
    end
    chk("mid_npulse", 32'(pc), 32'd1);
    chk("mid_pcyc", 32'(pcyc), 32'd5);

    // async reset mid-run
    load(32'h0BADF00D, 32'h1111, 32'h2222);
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("ar_busy", 32'(bsy[2]), 32'd0);
    chk("ar_dat", dato[2], 32'd0);
    chk("ar_unst", 32'(unst[2] | unst[1] | unst[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    pc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (unst[0] | unst[1] | unst[2]) pc++;
    end
    chk("ar_nopulse", 32'(pc), 32'd0);

    load(32'h1, 32'h0, 32'h0);
    pcyc = -1;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      if (unst[2] && pcyc < 0) pcyc = c;
    end
    chk("ar_relaunch", 32'(pcyc), 32'd5);
    chk("ar_relaunch_dat", dato[0], 32'h20);

    @(negedge clk);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
